fc_layer_seq: RTL and testbench

FC_LAYER_SEQ -- requirements
Module: fc_layer_seq

---
 rtl/fc_layer_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_fc_layer_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequences a fully-connected accelerator core through a chain
// of layers described in a small descriptor table.
//
// For each layer the sequencer pulses core_rst, streams the layer inputs,
// the weight matrix and (optionally) the bias vector from memory into the
// core, then drains the core's outputs back to memory.
//
// Ports
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   cfg_we/idx/wdata  descriptor table write port (writable at any time)
//   start/num_layers  launch a run of num_layers descriptors starting at 0
//   busy/done         run in progress / one-cycle completion pulse
//   mem_*             single-port memory; read data returns one cycle after mem_ren
//   core_*            configuration, input stream and output stream of the core
module fc_layer_seq #(
  parameter int MAX_LAYERS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic [75:0] cfg_wdata,
  input  logic        start,
  input  logic [3:0]  num_layers,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic        mem_ren,
  input  logic [15:0] mem_rdata,
  output logic        mem_wen,
  output logic [15:0] mem_wdata,
  output logic        core_rst,
  output logic [10:0] core_cin,
  output logic [10:0] core_cout,
  output logic        core_has_bias,
  output logic [4:0]  core_act_type,
  output logic        core_din_valid,
  output logic [15:0] core_din_data,
  input  logic        core_dout_valid,
  output logic        core_dout_ready,
  input  logic [15:0] core_dout_data
);

  typedef enum logic [3:0] {
    IDLE, CRST, LD_IN, GAP_IN, LD_W, GAP_W, LD_B, GAP_B, DRAIN, NEXT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  layer_q, layer_d;
  logic [3:0]  num_q, num_d;
  logic [21:0] cnt_q, cnt_d;
  logic [75:0] desc_q, desc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        core_rst_q, core_rst_d;
  logic        ren_q;

  logic [75:0] table_q [MAX_LAYERS];

  logic [3:0]  nextLayer;
  logic [3:0]  lookupIdx;
  logic [75:0] descSel;
  logic        startOk;

  // Working copy of the running layer's descriptor; table writes during a
  // run do not disturb it.
  logic [10:0] cin, cout;
  logic        hasBias;
  logic [15:0] inBase, wgtBase, outBase;
  logic [21:0] prodW;

  assign cin     = desc_q[10:0];
  assign cout    = desc_q[21:11];
  assign hasBias = desc_q[22];
  assign inBase  = desc_q[43:28];
  assign wgtBase = desc_q[59:44];
  assign outBase = desc_q[75:60];

  // Full 22-bit weight count; only its low 16 bits feed address arithmetic.
  assign prodW = {11'd0, cin} * {11'd0, cout};

  assign nextLayer = layer_q + 4'd1;
  assign startOk   = start && !cfg_we && (num_layers != 4'd0) &&
                     (32'(num_layers) <= MAX_LAYERS);

  // The table is read either for layer 0 at launch or for the following
  // layer when leaving NEXT.
  assign lookupIdx = (state_q == NEXT) ? nextLayer : 4'd0;

  always_comb begin
    descSel = '0;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      if (lookupIdx == 4'(i)) descSel = table_q[i];
    end
  end

  // Descriptor table has no reset so its contents survive an aborted run.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LAYERS; i++) begin
      if (cfg_we && (cfg_idx == 3'(i))) table_q[i] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      layer_q    <= 4'd0;
      num_q      <= 4'd0;
      cnt_q      <= 22'd0;
      desc_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
      ren_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      desc_q     <= desc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      ren_q      <= mem_ren;
    end
  end

  always_comb begin
    state_d         = state_q;
    layer_d         = layer_q;
    num_d           = num_q;
    cnt_d           = cnt_q;
    desc_d          = desc_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    mem_ren         = 1'b0;
    mem_wen         = 1'b0;
    mem_addr        = 16'h0000;
    core_dout_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (startOk) begin
          layer_d = 4'd0;
          num_d   = num_layers;
          busy_d  = 1'b1;
          desc_d  = descSel;
          state_d = CRST;
        end
      end
      CRST: begin
        cnt_d   = 22'd0;
        // Empty layers are skipped without touching memory.
        state_d = ((cin == 11'd0) || (cout == 11'd0)) ? NEXT : LD_IN;
      end
      LD_IN: begin
        mem_ren  = 1'b1;
        mem_addr = inBase + cnt_q[15:0];
        if (cnt_q == {11'd0, cin} - 22'd1) begin
          cnt_d   = 22'd0;
          state_d = GAP_IN;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      GAP_IN: state_d = LD_W;
      LD_W: begin
        mem_ren  = 1'b1;
        mem_addr = wgtBase + cnt_q[15:0];
        if (cnt_q == prodW - 22'd1) begin
          cnt_d   = 22'd0;
          state_d = GAP_W;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      GAP_W: state_d = hasBias ? LD_B : DRAIN;
      LD_B: begin
        // Bias vector sits directly after the weight matrix.
        mem_ren  = 1'b1;
        mem_addr = wgtBase + prodW[15:0] + cnt_q[15:0];
        if (cnt_q == {11'd0, cout} - 22'd1) begin
          cnt_d   = 22'd0;
          state_d = GAP_B;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      GAP_B: state_d = DRAIN;
      DRAIN: begin
        core_dout_ready = 1'b1;
        mem_addr        = outBase + cnt_q[15:0];
        if (core_dout_valid) begin
          mem_wen = 1'b1;
          if (cnt_q == {11'd0, cout} - 22'd1) begin
            cnt_d   = 22'd0;
            state_d = NEXT;
          end else begin
            cnt_d = cnt_q + 22'd1;
          end
        end
      end
      NEXT: begin
        layer_d = nextLayer;
        if (nextLayer == num_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          desc_d  = descSel;
          state_d = CRST;
        end
      end
      default: state_d = IDLE;
    endcase

    core_rst_d = (state_d == CRST);
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign core_rst       = core_rst_q;
  assign core_din_valid = ren_q;
  assign core_din_data  = mem_rdata;
  assign mem_wdata      = core_dout_data;
  assign core_cin       = cin;
  assign core_cout      = cout;
  assign core_has_bias  = hasBias;
  assign core_act_type  = desc_q[27:23];

endmodule

// File: tb/tb_fc_layer_seq.sv
// Testbench for fc_layer_seq: behavioural memory and core models, with a
// scoreboard of expected read addresses and expected (address, data) writes.
module tb_fc_layer_seq;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [75:0] cfg_wdata;
  logic        start;
  logic [3:0]  num_layers;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic        mem_ren;
  logic [15:0] mem_rdata;
  logic        mem_wen;
  logic [15:0] mem_wdata;
  logic        core_rst;
  logic [10:0] core_cin;
  logic [10:0] core_cout;
  logic        core_has_bias;
  logic [4:0]  core_act_type;
  logic        core_din_valid;
  logic [15:0] core_din_data;
  logic        core_dout_valid;
  logic        core_dout_ready;
  logic [15:0] core_dout_data;

  fc_layer_seq #(.MAX_LAYERS(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .start(start), .num_layers(num_layers), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .core_cin(core_cin), .core_cout(core_cout),
    .core_has_bias(core_has_bias), .core_act_type(core_act_type),
    .core_din_valid(core_din_valid), .core_din_data(core_din_data),
    .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready),
    .core_dout_data(core_dout_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] rdQ [$];
  logic [31:0] wrQ [$];
  bit          sbOff = 1'b0;
  bit          stallEn = 1'b0;

  int doneCnt, rstPulses, renFalls, dinBeats, wrCnt;
  bit prevRen, prevCoreRst, seenHigh;
  int lowRun;
  logic [15:0] expA;
  logic [31:0] expW;

  // Memory model: one-cycle read latency, writes land on the clock edge.
  logic [15:0] memArr [65536];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= memArr[mem_addr];
    if (mem_wen) memArr[mem_addr] <= mem_wdata;
  end

  // Core model: sums every input beat of the layer, then emits cout words
  // (sum + k), optionally stalling for three cycles early in the drain.
  int          beats, kOut, drainCyc, coreTotal;
  logic [15:0] coreSum;
  logic        loaded;
  assign coreTotal = int'(core_cin) + int'(core_cin) * int'(core_cout) +
                     (core_has_bias ? int'(core_cout) : 0);
  assign loaded = (beats == coreTotal);
  assign core_dout_valid = !core_rst && busy && loaded && (kOut < int'(core_cout)) &&
                           !(stallEn && drainCyc >= 1 && drainCyc <= 3);
  assign core_dout_data = coreSum + 16'(kOut);

  always @(posedge clk) begin
    if (core_rst) begin
      beats <= 0; coreSum <= 16'h0; kOut <= 0; drainCyc <= 0;
    end else begin
      if (core_din_valid) begin
        beats   <= beats + 1;
        coreSum <= coreSum + core_din_data;
      end
      if (loaded) drainCyc <= drainCyc + 1;
      if (core_dout_valid && core_dout_ready) kOut <= kOut + 1;
    end
  end

  // Monitor: pops the scoreboard on every memory access and tracks pulses,
  // phase ends and the length of input-stream gaps.
  always @(negedge clk) begin
    if (rst) begin
      prevRen = 1'b0; prevCoreRst = 1'b1; seenHigh = 1'b0; lowRun = 0;
    end else begin
      if (!sbOff && mem_ren) begin
        checks++;
        if (rdQ.size() == 0) begin
          errors++; $display("[TB] FAIL readAddr got %h required no read", mem_addr);
        end else begin
          expA = rdQ.pop_front();
          if (mem_addr !== expA) begin
            errors++; $display("[TB] FAIL readAddr got %h required %h", mem_addr, expA);
          end
        end
      end
      if (!sbOff && mem_wen) begin
        checks++; wrCnt++;
        if (wrQ.size() == 0) begin
          errors++; $display("[TB] FAIL write got %h:%h required no write", mem_addr, mem_wdata);
        end else begin
          expW = wrQ.pop_front();
          if ({mem_addr, mem_wdata} !== expW) begin
            errors++;
            $display("[TB] FAIL write got %h:%h required %h:%h", mem_addr, mem_wdata, expW[31:16], expW[15:0]);
          end
        end
      end
      if (busy) begin
        checks++;
        if (mem_ren && mem_wen) begin
          errors++; $display("[TB] FAIL renWen got both=1 required not both");
        end
      end
      if (core_dout_ready && !core_dout_valid) begin
        checks++;
        if (mem_wen !== 1'b0) begin
          errors++; $display("[TB] FAIL stallWen got %b required 0", mem_wen);
        end
      end
      if (done) doneCnt++;
      if (core_rst && !prevCoreRst) rstPulses++;
      if (prevRen && !mem_ren) renFalls++;
      if (core_din_valid) dinBeats++;
      if (core_rst) begin
        seenHigh = 1'b0; lowRun = 0;
      end else if (core_din_valid) begin
        if (seenHigh && lowRun > 0) begin
          checks++;
          if (lowRun != 1) begin
            errors++; $display("[TB] FAIL gapLen got %0d required 1", lowRun);
          end
        end
        seenHigh = 1'b1; lowRun = 0;
      end else if (seenHigh) begin
        lowRun++;
      end
      prevRen = mem_ren; prevCoreRst = core_rst;
    end
  end

  task automatic resetCounters();
    doneCnt = 0; rstPulses = 0; renFalls = 0; dinBeats = 0; wrCnt = 0;
  endtask

  task automatic writeDesc(input int idx, input int cin, input int cout, input bit bias,
                           input int inB, input int wB, input int oB);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_wdata = {16'(oB), 16'(wB), 16'(inB), 5'd3, bias, 11'(cout), 11'(cin)};
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic fillRange(input int base, input int n, input int seed, output logic [15:0] sum);
    logic [15:0] v;
    sum = 16'h0;
    for (int i = 0; i < n; i++) begin
      v = 16'(seed + i * 37);
      memArr[16'(base + i)] <= v;
      sum += v;
    end
  endtask

  task automatic pushReads(input int base, input int n);
    for (int i = 0; i < n; i++) rdQ.push_back(16'(base + i));
  endtask

  task automatic pushWrites(input int oB, input int n, input logic [15:0] sum);
    for (int i = 0; i < n; i++) wrQ.push_back({16'(oB + i), 16'(sum + 16'(i))});
  endtask

  task automatic applyStimulus(input int n);
    @(negedge clk);
    start = 1'b1; num_layers = 4'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstBusy got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstDone got %b required 0", done); end
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("[TB] FAIL rstRen got %b required 0", mem_ren); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL rstWen got %b required 0", mem_wen); end
    checks++; if (core_din_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstDinValid got %b required 0", core_din_valid); end
    checks++; if (core_dout_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstDoutReady got %b required 0", core_dout_ready); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("[TB] FAIL rstCoreRst got %b required 1", core_rst); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic runBasic(input bit bias, input string tag);
    logic [15:0] sIn, sW, sum;
    bit got;
    writeDesc(0, 4, 2, bias, 'h100, 'h200, 'h300);
    fillRange('h100, 4, 'h0011, sIn);
    fillRange('h200, bias ? 10 : 8, 'h1000, sW);
    sum = sIn + sW;
    pushReads('h100, 4);
    pushReads('h200, bias ? 10 : 8);
    pushWrites('h300, 2, sum);
    resetCounters();
    applyStimulus(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s busyAfterStart got %b required 1", tag, busy); end
    waitDone(200, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL %s doneTimeout got 0 required 1", tag); end
    checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL %s doneCycles got %0d required 1", tag, doneCnt); end
    checks++; if (rstPulses != 1) begin errors++; $display("[TB] FAIL %s coreRstPulses got %0d required 1", tag, rstPulses); end
    checks++; if (renFalls != (bias ? 3 : 2)) begin errors++; $display("[TB] FAIL %s gaps got %0d required %0d", tag, renFalls, bias ? 3 : 2); end
    checks++; if (dinBeats != (bias ? 14 : 12)) begin errors++; $display("[TB] FAIL %s dinBeats got %0d required %0d", tag, dinBeats, bias ? 14 : 12); end
    checks++; if (rdQ.size() != 0 || wrQ.size() != 0) begin errors++; $display("[TB] FAIL %s pending got %0d/%0d required 0/0", tag, rdQ.size(), wrQ.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busyAfterDone got %b required 0", tag, busy); end
    rdQ.delete(); wrQ.delete();
  endtask

  task automatic test_single_layer();
    runBasic(1'b0, "single");
  endtask

  task automatic test_bias();
    runBasic(1'b1, "bias");
  endtask

  task automatic test_two_layers();
    logic [15:0] s0In, s0W, s0, s1W, s1;
    bit got;
    writeDesc(0, 2, 3, 1'b0, 'h400, 'h500, 'h600);
    writeDesc(1, 3, 2, 1'b1, 'h600, 'h700, 'h800);
    fillRange('h400, 2, 'h0101, s0In);
    fillRange('h500, 6, 'h2020, s0W);
    fillRange('h700, 8, 'h0303, s1W);
    s0 = s0In + s0W;
    s1 = (s0 + s0 + s0 + 16'd3) + s1W;
    pushReads('h400, 2); pushReads('h500, 6);
    pushReads('h600, 3); pushReads('h700, 8);
    pushWrites('h600, 3, s0);
    pushWrites('h800, 2, s1);
    resetCounters();
    applyStimulus(2);
    waitDone(300, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL twoLayer doneTimeout got 0 required 1"); end
    checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL twoLayer doneCycles got %0d required 1", doneCnt); end
    checks++; if (rstPulses != 2) begin errors++; $display("[TB] FAIL twoLayer coreRstPulses got %0d required 2", rstPulses); end
    checks++; if (wrCnt != 5) begin errors++; $display("[TB] FAIL twoLayer writes got %0d required 5", wrCnt); end
    checks++; if (rdQ.size() != 0 || wrQ.size() != 0) begin errors++; $display("[TB] FAIL twoLayer pending got %0d/%0d required 0/0", rdQ.size(), wrQ.size()); end
    rdQ.delete(); wrQ.delete();
  endtask

  task automatic test_drain_stall();
    logic [15:0] sIn, sW;
    bit got;
    writeDesc(0, 2, 4, 1'b0, 'h900, 'hA00, 'hB00);
    fillRange('h900, 2, 'h0505, sIn);
    fillRange('hA00, 8, 'h0707, sW);
    pushReads('h900, 2); pushReads('hA00, 8);
    pushWrites('hB00, 4, sIn + sW);
    resetCounters();
    stallEn = 1'b1;
    applyStimulus(1);
    waitDone(200, got);
    stallEn = 1'b0;
    checks++; if (!got) begin errors++; $display("[TB] FAIL stall doneTimeout got 0 required 1"); end
    checks++; if (wrCnt != 4) begin errors++; $display("[TB] FAIL stall writes got %0d required 4", wrCnt); end
    checks++; if (rdQ.size() != 0 || wrQ.size() != 0) begin errors++; $display("[TB] FAIL stall pending got %0d/%0d required 0/0", rdQ.size(), wrQ.size()); end
    rdQ.delete(); wrQ.delete();
  endtask

  task automatic test_reset_midrun();
    logic [15:0] sIn, sW;
    bit got, hit;
    writeDesc(0, 4, 2, 1'b0, 'h100, 'h200, 'h300);
    fillRange('h100, 4, 'h0A0A, sIn);
    fillRange('h200, 8, 'h0B0B, sW);
    sbOff = 1'b1;
    applyStimulus(1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (mem_ren && mem_addr >= 16'h200) hit = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL abort reachLdW got 0 required 1"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort busy got %b required 0", busy); end
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("[TB] FAIL abort ren got %b required 0", mem_ren); end
    checks++; if (core_din_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort dinValid got %b required 0", core_din_valid); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("[TB] FAIL abort coreRst got %b required 1", core_rst); end
    checks++; if (core_dout_ready !== 1'b0 || mem_wen !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL abort rdyWenDone got %b%b%b required 000", core_dout_ready, mem_wen, done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rdQ.delete(); wrQ.delete();
    sbOff = 1'b0;
    pushReads('h100, 4); pushReads('h200, 8);
    pushWrites('h300, 2, sIn + sW);
    resetCounters();
    applyStimulus(1);
    waitDone(200, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL rerun doneTimeout got 0 required 1"); end
    checks++; if (dinBeats != 12) begin errors++; $display("[TB] FAIL rerun dinBeats got %0d required 12", dinBeats); end
    checks++; if (rdQ.size() != 0 || wrQ.size() != 0) begin errors++; $display("[TB] FAIL rerun pending got %0d/%0d required 0/0", rdQ.size(), wrQ.size()); end
    rdQ.delete(); wrQ.delete();
  endtask

  task automatic test_ignored_starts();
    logic [15:0] sIn, sW;
    bit got;
    resetCounters();
    applyStimulus(0);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || doneCnt != 0) begin errors++; $display("[TB] FAIL zeroLayers busy/done got %b/%0d required 0/0", busy, doneCnt); end
    applyStimulus(9);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tooManyLayers busy got %b required 0", busy); end
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'd7; cfg_wdata = '0; start = 1'b1; num_layers = 4'd1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL startDuringCfg busy got %b required 0", busy); end
    writeDesc(0, 4, 2, 1'b0, 'h100, 'h200, 'h300);
    fillRange('h100, 4, 'h0C0C, sIn);
    fillRange('h200, 8, 'h0D0D, sW);
    pushReads('h100, 4); pushReads('h200, 8);
    pushWrites('h300, 2, sIn + sW);
    resetCounters();
    applyStimulus(1);
    repeat (4) @(negedge clk);
    applyStimulus(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL startWhileBusy busy got %b required 1", busy); end
    waitDone(200, got);
    checks++; if (!got || doneCnt != 1) begin errors++; $display("[TB] FAIL startWhileBusy doneCycles got %0d required 1", doneCnt); end
    checks++; if (rstPulses != 1) begin errors++; $display("[TB] FAIL startWhileBusy coreRstPulses got %0d required 1", rstPulses); end
    checks++; if (rdQ.size() != 0 || wrQ.size() != 0) begin errors++; $display("[TB] FAIL startWhileBusy pending got %0d/%0d required 0/0", rdQ.size(), wrQ.size()); end
    rdQ.delete(); wrQ.delete();
  endtask

  task automatic test_skip_layer();
    logic [15:0] sIn, sW;
    bit got;
    writeDesc(0, 0, 3, 1'b0, 'h100, 'h200, 'h300);
    writeDesc(1, 2, 1, 1'b0, 'hC00, 'hD00, 'hE00);
    fillRange('hC00, 2, 'h0E0E, sIn);
    fillRange('hD00, 2, 'h0F0F, sW);
    pushReads('hC00, 2); pushReads('hD00, 2);
    pushWrites('hE00, 1, sIn + sW);
    resetCounters();
    applyStimulus(2);
    waitDone(200, got);
    checks++; if (!got || doneCnt != 1) begin errors++; $display("[TB] FAIL skip doneCycles got %0d required 1", doneCnt); end
    checks++; if (rstPulses != 2) begin errors++; $display("[TB] FAIL skip coreRstPulses got %0d required 2", rstPulses); end
    checks++; if (rdQ.size() != 0 || wrQ.size() != 0) begin errors++; $display("[TB] FAIL skip pending got %0d/%0d required 0/0", rdQ.size(), wrQ.size()); end
    rdQ.delete(); wrQ.delete();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_wdata = '0;
    start = 1'b0; num_layers = 4'd0;
    resetCounters();
    repeat (3) @(negedge clk);
    test_reset();
    test_single_layer();
    test_bias();
    test_two_layers();
    test_drain_stall();
    test_reset_midrun();
    test_ignored_starts();
    test_skip_layer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
